dmem_arbiter: RTL

Shares the single data-memory port between two requesters: the pipeline MEM stage (core), which issues load/store beats, and the interrupt context save/restore engine (ctx), which issues bursts of word beats on interrupt entry and exit.
- Sits between those requesters and the DMEM macro.
- Grants one beat per cycle and routes the one-cycle-latency read data back to whichever requester issued the read.
- Holds the grant for locked ctx bursts.
- Drives back-pressure (ready) that the hazard unit uses as a stall.

---
 rtl/dmem_arb_pkg.sv | 6 +
 rtl/dmem_arb_resp_route.sv | 36 +++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM state, response owner, full write mask.
package dmem_arb_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
  typedef enum logic {CORE = 1'b0, CTX = 1'b1} owner_t;
  localparam logic [3:0] WMASK_FULL = 4'hF;
endpackage

// File: rtl/dmem_arb_resp_route.sv
// Tracks the single outstanding DMEM read and steers its one-cycle-late data
// to the requester that issued it.
module dmem_arb_resp_route
  import dmem_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          rd_grant,
  input  owner_t        rd_owner,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  output logic          ctx_rvalid,
  output logic [DW-1:0] ctx_rdata
);
  logic   pend;
  owner_t owner;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend  <= 1'b0;
      owner <= CORE;
    end else begin
      pend <= rd_grant;
      if (rd_grant) owner <= rd_owner;
    end
  end

  // Data is gated, not held: outside an rvalid cycle both rdata buses read 0.
  assign core_rvalid = pend && (owner == CORE);
  assign ctx_rvalid  = pend && (owner == CTX);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign ctx_rdata   = ctx_rvalid  ? mem_rdata : '0;
endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester DMEM arbiter (core MEM stage vs. interrupt ctx engine) with locked ctx bursts.
// Optional core anti-starvation forcing is enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          core_valid_i,
  input  logic          core_we_i,
  input  logic [3:0]    core_wmask_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic          core_ready_o,
  output logic          core_rvalid_o,
  output logic [DW-1:0] core_rdata_o,
  input  logic          ctx_valid_i,
  input  logic          ctx_lock_i,
  input  logic          ctx_we_i,
  input  logic [AW-1:0] ctx_addr_i,
  input  logic [DW-1:0] ctx_wdata_i,
  output logic          ctx_ready_o,
  output logic          ctx_rvalid_o,
  output logic [DW-1:0] ctx_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_wmask_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);
  state_t state, state_nxt;
  logic   force_core, core_xfer, ctx_xfer, rd_grant;
  owner_t rd_owner;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] starve_cnt;

  assign force_core = (state == IDLE) && core_valid_i && (starve_cnt == CW'(MAX_WAIT));

  // Counter only moves in IDLE, so a locked burst can never be broken by it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      starve_cnt <= '0;
    else if (core_xfer)
      starve_cnt <= '0;
    else if (state == IDLE && core_valid_i && !core_ready_o && starve_cnt != CW'(MAX_WAIT))
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign force_core = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    core_ready_o = 1'b0;
    ctx_ready_o  = 1'b0;
    case (state)
      IDLE: begin
        ctx_ready_o  = !force_core;
        core_ready_o = !(ctx_valid_i && !force_core);
        if (ctx_valid_i && !force_core && ctx_lock_i) state_nxt = LOCKED;
      end
      LOCKED: begin
        // Grant stays with ctx even across bubbles until the unlocked last beat.
        ctx_ready_o = 1'b1;
        if (ctx_valid_i && !ctx_lock_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign core_xfer = core_valid_i && core_ready_o;
  assign ctx_xfer  = ctx_valid_i && ctx_ready_o;

  always_comb begin
    mem_en_o = core_xfer || ctx_xfer;
    if (ctx_xfer) begin
      mem_we_o    = ctx_we_i;
      mem_wmask_o = ctx_we_i ? WMASK_FULL : 4'h0;
      mem_addr_o  = ctx_addr_i;
      mem_wdata_o = ctx_wdata_i;
    end else begin
      mem_we_o    = core_xfer && core_we_i;
      mem_wmask_o = core_xfer ? core_wmask_i : 4'h0;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end
  end

  assign rd_grant = mem_en_o && !mem_we_o;
  assign rd_owner = ctx_xfer ? CTX : CORE;

  dmem_arb_resp_route #(.DW(DW)) u_resp (
    .clk         (clk),
    .resetn      (resetn),
    .rd_grant    (rd_grant),
    .rd_owner    (rd_owner),
    .mem_rdata   (mem_rdata_i),
    .core_rvalid (core_rvalid_o),
    .core_rdata  (core_rdata_o),
    .ctx_rvalid  (ctx_rvalid_o),
    .ctx_rdata   (ctx_rdata_o)
  );
endmodule
